// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC unit: branch-type encodings, reset PC default
// and the saturating-counter step used by the optional branch target buffer.
package npc_pkg;

    localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6,
        BR_RSVD = 3'd7
    } br_type_e;

    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
        if (up) begin
            return (ctr == 2'd3) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'd0) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// Addresses arrive as word addresses (pc[31:2]); lookups always see pre-update contents.
module npc_btb
    import npc_pkg::*;
#(
    parameter int DEPTH = 16
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] i_lk_word,
    output logic        o_lk_pred,
    output logic [31:0] o_lk_tgt,
    input  logic        i_up_en,
    input  logic [29:0] i_up_word,
    input  logic        i_up_taken,
    input  logic [31:0] i_up_tgt
);

    localparam int IW = $clog2(DEPTH);
    localparam int TW = 30 - IW;

    logic [DEPTH-1:0] r_valid;
    logic [TW-1:0]    r_tag [DEPTH];
    logic [31:0]      r_tgt [DEPTH];
    logic [1:0]       r_ctr [DEPTH];

    logic [IW-1:0] w_lk_idx;
    logic [IW-1:0] w_up_idx;
    logic          w_lk_hit;
    logic          w_up_hit;
    logic          w_write;

    assign w_lk_idx  = i_lk_word[IW-1:0];
    assign w_up_idx  = i_up_word[IW-1:0];
    assign w_lk_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == i_lk_word[29:IW]);
    assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == i_up_word[29:IW]);
    assign o_lk_pred = w_lk_hit && r_ctr[w_lk_idx][1];
    assign o_lk_tgt  = r_tgt[w_lk_idx];

    // A miss that resolves not-taken leaves the table alone; everything else writes.
    assign w_write = i_up_en && (w_up_hit || i_up_taken);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_write) begin
            r_valid[w_up_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_tag[w_up_idx] <= i_up_word[29:IW];
            r_tgt[w_up_idx] <= i_up_tgt;
            r_ctr[w_up_idx] <= w_up_hit ? sat_step(r_ctr[w_up_idx], i_up_taken) : 2'd2;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC register with decode-stage branch resolution and mispredict redirect.
// Define NPC_BTB_EN to build in the npc_btb predictor; otherwise fetch always predicts fall-through.
module next_pc_unit
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = NPC_RESET_PC,
    parameter int          BTB_DEPTH = 16
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        valid_d,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc_d,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [2:0]  br_type,
    input  logic        jump,
    input  logic        jr,
    input  logic        pred_d,
    input  logic [31:0] pred_tgt_d,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus4_f,
    output logic        pred_f,
    output logic [31:0] pred_tgt_f,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_f
);

    logic [31:0] r_pc;
    logic [31:0] w_pc4_d;
    logic [31:0] w_br_tgt;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_target;
    logic [31:0] w_actual_next;
    logic        w_cond;
    logic        w_taken;
    logic        w_mispredict;
    logic        w_redirect;
    br_type_e    w_br;
    logic        w_unused;

    assign w_br      = br_type_e'(br_type);
    assign w_pc4_d   = pc_d + 32'd4;
    assign w_br_tgt  = w_pc4_d + {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
    assign w_jmp_tgt = {w_pc4_d[31:28], instr_d[25:0], 2'b00};

    always_comb begin
        w_cond = 1'b0;
        case (w_br)
            BR_BEQ:  w_cond = (rs_val == rt_val);
            BR_BNE:  w_cond = (rs_val != rt_val);
            BR_BLEZ: w_cond = ($signed(rs_val) <= 0);
            BR_BGTZ: w_cond = ($signed(rs_val) > 0);
            BR_BLTZ: w_cond = ($signed(rs_val) < 0);
            BR_BGEZ: w_cond = ($signed(rs_val) >= 0);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_target      = jr ? rs_val : (jump ? w_jmp_tgt : w_br_tgt);
    assign w_taken       = jr | jump | w_cond;
    assign w_actual_next = w_taken ? w_target : w_pc4_d;
    assign w_mispredict  = (pred_d != w_taken) | (pred_d & w_taken & (pred_tgt_d != w_target));

    // Reset and stall both mask the correction so a stalled redirect is simply re-evaluated later.
    assign w_redirect  = valid_d & ~stall & ~reset & w_mispredict;
    assign redirect    = w_redirect;
    assign flush_f     = w_redirect;
    assign redirect_pc = w_actual_next;

    assign pc_f       = r_pc;
    assign pc_plus4_f = r_pc + 32'd4;

    // Opcode bits are decoded upstream; the depth check only matters when the BTB is built in.
    assign w_unused = (^instr_d[31:26]) ^ (BTB_DEPTH < 2);

`ifdef NPC_BTB_EN
    logic        w_btb_upd;
    logic        w_lk_pred;
    logic [31:0] w_lk_tgt;

    assign w_btb_upd = valid_d & ~stall & ~reset & ~jr & ((br_type != 3'd0) | jump);

    npc_btb #(
        .DEPTH(BTB_DEPTH)
    ) u_btb (
        .clk        (clk),
        .reset      (reset),
        .i_lk_word  (r_pc[31:2]),
        .o_lk_pred  (w_lk_pred),
        .o_lk_tgt   (w_lk_tgt),
        .i_up_en    (w_btb_upd),
        .i_up_word  (pc_d[31:2]),
        .i_up_taken (w_taken),
        .i_up_tgt   (w_target)
    );

    assign pred_f     = w_lk_pred & ~reset;
    assign pred_tgt_f = pred_f ? w_lk_tgt : pc_plus4_f;
`else
    assign pred_f     = 1'b0;
    assign pred_tgt_f = pc_plus4_f;
`endif

    // pred_tgt_f already folds in the fall-through case, so it is the default next fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (!stall) begin
            r_pc <= w_redirect ? w_actual_next : pred_tgt_f;
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: a per-cycle reference model plus directed
// vectors with hand-computed redirects. Build with NPC_BTB_EN to cover the predictor.
module tb_next_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int          DEPTH  = 16;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [2:0]  br_type;
    logic        jump;
    logic        jr;
    logic        pred_d;
    logic [31:0] pred_tgt_d;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        pred_f;
    logic [31:0] pred_tgt_f;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_f;

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 1'b0;

    logic [31:0] mPcF;
`ifdef NPC_BTB_EN
    bit          mV   [DEPTH];
    logic [31:0] mAddr[DEPTH];
    logic [31:0] mTgt [DEPTH];
    int          mCtr [DEPTH];
`endif

    typedef struct {
        logic [2:0]  bt;
        logic        jmp;
        logic        jrr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic        pd;
        logic [31:0] ptgt;
        logic        expRedir;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs[16];

    next_pc_unit #(
        .RESET_PC (RST_PC),
        .BTB_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .valid_d    (valid_d),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .br_type    (br_type),
        .jump       (jump),
        .jr         (jr),
        .pred_d     (pred_d),
        .pred_tgt_d (pred_tgt_d),
        .pc_f       (pc_f),
        .pc_plus4_f (pc_plus4_f),
        .pred_f     (pred_f),
        .pred_tgt_f (pred_tgt_f),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .flush_f    (flush_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural rules computed straight from the decode inputs.
    function automatic logic [31:0] modelTarget();
        int off;
        if (jr) return rs_val;
        if (jump) return {pc_d[31:28] + ((pc_d[27:0] + 28'd4 == 28'd0) ? 4'd1 : 4'd0), instr_d[25:0], 2'b00};
        off = $signed(instr_d[15:0]);
        return pc_d + 32'd4 + 32'(off * 4);
    endfunction

    function automatic bit modelTaken();
        bit c;
        case (br_type)
            3'd1: c = (rs_val == rt_val);
            3'd2: c = (rs_val != rt_val);
            3'd3: c = ($signed(rs_val) <= 0);
            3'd4: c = ($signed(rs_val) > 0);
            3'd5: c = ($signed(rs_val) < 0);
            3'd6: c = ($signed(rs_val) >= 0);
            default: c = 1'b0;
        endcase
        return jr || jump || c;
    endfunction

    function automatic bit modelRedirect();
        bit t;
        bit mis;
        t   = modelTaken();
        mis = (pred_d != t) || (pred_d && t && (pred_tgt_d != modelTarget()));
        return valid_d && !stall && !reset && mis;
    endfunction

    function automatic logic [31:0] modelNext();
        return modelTaken() ? modelTarget() : pc_d + 32'd4;
    endfunction

    function automatic int idxOf(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit modelPred();
`ifdef NPC_BTB_EN
        int i;
        i = idxOf(mPcF);
        return !reset && mV[i] && (mAddr[i] == mPcF) && (mCtr[i] >= 2);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] modelPredTgt();
`ifdef NPC_BTB_EN
        if (modelPred()) return mTgt[idxOf(mPcF)];
`endif
        return mPcF + 32'd4;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mPcF <= RST_PC;
`ifdef NPC_BTB_EN
            for (int k = 0; k < DEPTH; k++) mV[k] <= 1'b0;
`endif
        end else if (!stall) begin
            mPcF <= modelRedirect() ? modelNext() : modelPredTgt();
`ifdef NPC_BTB_EN
            if (valid_d && !jr && (br_type != 3'd0 || jump)) begin
                int i;
                i = idxOf(pc_d);
                if (mV[i] && mAddr[i] == pc_d) begin
                    mCtr[i] <= modelTaken() ? ((mCtr[i] < 3) ? mCtr[i] + 1 : 3)
                                            : ((mCtr[i] > 0) ? mCtr[i] - 1 : 0);
                    mTgt[i] <= modelTarget();
                end else if (modelTaken()) begin
                    mV[i]    <= 1'b1;
                    mAddr[i] <= pc_d;
                    mTgt[i]  <= modelTarget();
                    mCtr[i]  <= 2;
                end
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("pc_f", pc_f, mPcF);
            checkOutput("pc_plus4_f", pc_plus4_f, mPcF + 32'd4);
            checkOutput("redirect", {31'b0, redirect}, {31'b0, modelRedirect()});
            checkOutput("flush_f", {31'b0, flush_f}, {31'b0, modelRedirect()});
            if (modelRedirect()) checkOutput("redirect_pc", redirect_pc, modelNext());
            checkOutput("pred_f", {31'b0, pred_f}, {31'b0, modelPred()});
            checkOutput("pred_tgt_f", pred_tgt_f, modelPredTgt());
        end
    end

    task automatic applyStimulus(input logic vld, input logic [2:0] bt, input logic jmp, input logic jrr,
                                 input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] instr,
                                 input logic [31:0] pcd, input logic pd, input logic [31:0] ptgt,
                                 input logic stl);
        @(posedge clk);
        #1;
        valid_d    = vld;
        br_type    = bt;
        jump       = jmp;
        jr         = jrr;
        rs_val     = rs;
        rt_val     = rt;
        instr_d    = instr;
        pc_d       = pcd;
        pred_d     = pd;
        pred_tgt_d = ptgt;
        stall      = stl;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic printSummary();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    endtask

    initial begin
        #200000;
        nFails++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        printSummary();
        $finish;
    end

    initial begin
        vecs[0]  = '{3'd1, 1'b0, 1'b0, 32'd5,         32'd5, 32'h0000_FFFC, 32'h0000_3010, 1'b0, 32'h0,      1'b1, 32'h0000_3004};
        vecs[1]  = '{3'd2, 1'b0, 1'b0, 32'd1,         32'd1, 32'h0000_0010, 32'h0000_3010, 1'b0, 32'h0,      1'b0, 32'h0};
        vecs[2]  = '{3'd2, 1'b0, 1'b0, 32'd1,         32'd2, 32'h0000_0010, 32'h0000_3010, 1'b1, 32'h3054,   1'b0, 32'h0};
        vecs[3]  = '{3'd2, 1'b0, 1'b0, 32'd1,         32'd2, 32'h0000_0010, 32'h0000_3010, 1'b1, 32'h3058,   1'b1, 32'h0000_3054};
        vecs[4]  = '{3'd3, 1'b0, 1'b0, 32'd0,         32'd0, 32'h0000_0010, 32'h0000_3010, 1'b0, 32'h0,      1'b1, 32'h0000_3054};
        vecs[5]  = '{3'd4, 1'b0, 1'b0, 32'd0,         32'd0, 32'h0000_0010, 32'h0000_3010, 1'b1, 32'h3054,   1'b1, 32'h0000_3014};
        vecs[6]  = '{3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'd0, 32'h0000_0010, 32'h0000_3010, 1'b0, 32'h0,      1'b1, 32'h0000_3054};
        vecs[7]  = '{3'd6, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'h0000_0010, 32'h0000_3010, 1'b1, 32'h3054,   1'b1, 32'h0000_3014};
        vecs[8]  = '{3'd6, 1'b0, 1'b0, 32'd0,         32'd0, 32'h0000_0010, 32'h0000_3010, 1'b0, 32'h0,      1'b1, 32'h0000_3054};
        vecs[9]  = '{3'd0, 1'b1, 1'b0, 32'd0,         32'd0, 32'h0800_0400, 32'h0000_3010, 1'b0, 32'h0,      1'b1, 32'h0000_1000};
        vecs[10] = '{3'd0, 1'b1, 1'b1, 32'h0000_5000, 32'd0, 32'h0800_0400, 32'h0000_3010, 1'b0, 32'h0,      1'b1, 32'h0000_5000};
        vecs[11] = '{3'd7, 1'b0, 1'b0, 32'd1,         32'd1, 32'h0000_0010, 32'h0000_3010, 1'b0, 32'h0,      1'b0, 32'h0};
        vecs[12] = '{3'd7, 1'b0, 1'b0, 32'd1,         32'd1, 32'h0000_0010, 32'h0000_3010, 1'b1, 32'h3054,   1'b1, 32'h0000_3014};
        vecs[13] = '{3'd0, 1'b1, 1'b0, 32'd0,         32'd0, 32'h0800_0400, 32'hF000_0010, 1'b0, 32'h0,      1'b1, 32'hF000_1000};
        vecs[14] = '{3'd1, 1'b0, 1'b0, 32'd7,         32'd7, 32'h0000_0010, 32'hFFFF_FFF0, 1'b0, 32'h0,      1'b1, 32'h0000_0034};
        vecs[15] = '{3'd4, 1'b0, 1'b0, 32'd1,         32'd0, 32'h0000_0010, 32'h0000_3010, 1'b1, 32'h3054,   1'b0, 32'h0};

        reset = 1'b1; stall = 1'b0; valid_d = 1'b0; instr_d = '0; pc_d = '0;
        rs_val = '0; rt_val = '0; br_type = '0; jump = 1'b0; jr = 1'b0;
        pred_d = 1'b0; pred_tgt_d = '0;

        // Reset held over two edges; the second cycle also carries a stalled jr that must be ignored.
        @(posedge clk);
        #1;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("rst_pc_f", pc_f, 32'h0000_3000);
        checkOutput("rst_pc_plus4", pc_plus4_f, 32'h0000_3004);
        checkOutput("rst_pred_f", {31'b0, pred_f}, 32'd0);
        checkOutput("rst_pred_tgt", pred_tgt_f, 32'h0000_3004);
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b1, 32'h4000, 32'd0, 32'd0, 32'h3010, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("rst_redirect", {31'b0, redirect}, 32'd0);
        checkOutput("rst_flush", {31'b0, flush_f}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; valid_d = 1'b0; jr = 1'b0; stall = 1'b0;
        @(negedge clk);
        checkOutput("seq_pc0", pc_f, 32'h0000_3000);
        idleCycle();
        @(negedge clk);
        checkOutput("seq_pc1", pc_f, 32'h0000_3004);
        idleCycle();
        @(negedge clk);
        checkOutput("seq_pc2", pc_f, 32'h0000_3008);

        // Backward beq mispredicted not-taken; corrected fetch one cycle later.
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 32'd5, 32'd5, 32'h0000_FFFC, 32'h3010, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("beq_redirect", {31'b0, redirect}, 32'd1);
        checkOutput("beq_redirect_pc", redirect_pc, 32'h0000_3004);
        checkOutput("beq_flush", {31'b0, flush_f}, 32'd1);
        idleCycle();
        @(negedge clk);
        checkOutput("beq_pc_next", pc_f, 32'h0000_3004);

        // Same beq under a three-cycle stall.
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 32'd5, 32'd5, 32'h0000_FFFC, 32'h3010, 1'b0, 32'd0, 1'b1);
            @(negedge clk);
            checkOutput("stall_redirect", {31'b0, redirect}, 32'd0);
            checkOutput("stall_pc_hold", pc_f, 32'h0000_3008);
        end
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 32'd5, 32'd5, 32'h0000_FFFC, 32'h3010, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("unstall_redirect", {31'b0, redirect}, 32'd1);
        checkOutput("unstall_redirect_pc", redirect_pc, 32'h0000_3004);
        idleCycle();
        @(negedge clk);
        checkOutput("unstall_pc_next", pc_f, 32'h0000_3004);

        // jr with correct and wrong predicted target.
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b1, 32'h4000, 32'd0, 32'd0, 32'h3010, 1'b1, 32'h4000, 1'b0);
        @(negedge clk);
        checkOutput("jr_hit_redirect", {31'b0, redirect}, 32'd0);
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b1, 32'h4000, 32'd0, 32'd0, 32'h3010, 1'b1, 32'h4004, 1'b0);
        @(negedge clk);
        checkOutput("jr_miss_redirect", {31'b0, redirect}, 32'd1);
        checkOutput("jr_miss_redirect_pc", redirect_pc, 32'h0000_4000);

        for (int v = 0; v < 16; v++) begin
            applyStimulus(1'b1, vecs[v].bt, vecs[v].jmp, vecs[v].jrr, vecs[v].rs, vecs[v].rt,
                          vecs[v].instr, vecs[v].pcd, vecs[v].pd, vecs[v].ptgt, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_redirect", v), {31'b0, redirect}, {31'b0, vecs[v].expRedir});
            if (vecs[v].expRedir) checkOutput($sformatf("vec%0d_redirect_pc", v), redirect_pc, vecs[v].expPc);
        end

        // Drive fetch to the top of the address space to exercise the +4 wrap.
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h3010, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("wrap_redirect_pc", redirect_pc, 32'hFFFF_FFFC);
        idleCycle();
        @(negedge clk);
        checkOutput("wrap_pc_f", pc_f, 32'hFFFF_FFFC);
        checkOutput("wrap_pc_plus4", pc_plus4_f, 32'h0000_0000);
        checkOutput("wrap_pred_f", {31'b0, pred_f}, 32'd0);
        idleCycle();
        @(negedge clk);
        checkOutput("wrap_pc_next", pc_f, 32'h0000_0000);

`ifdef NPC_BTB_EN
        // Loop branch at 0x3020 back to 0x3000 (imm -9) trains the BTB.
        for (int t = 0; t < 2; t++) begin
            applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 32'd3, 32'd3, 32'h0000_FFF7, 32'h3020, 1'b0, 32'd0, 1'b0);
            @(negedge clk);
            checkOutput("loop_train_redirect_pc", redirect_pc, 32'h0000_3000);
        end
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b1, 32'h3020, 32'd0, 32'd0, 32'h3010, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 32'd3, 32'd3, 32'h0000_FFF7, 32'h3020, 1'b1, 32'h3000, 1'b0);
        @(negedge clk);
        checkOutput("loop_fetch_pc", pc_f, 32'h0000_3020);
        checkOutput("loop_pred_f", {31'b0, pred_f}, 32'd1);
        checkOutput("loop_pred_tgt", pred_tgt_f, 32'h0000_3000);
        checkOutput("loop_no_redirect", {31'b0, redirect}, 32'd0);
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 32'd3, 32'd4, 32'h0000_FFF7, 32'h3020, 1'b1, 32'h3000, 1'b0);
        @(negedge clk);
        checkOutput("loop_exit_redirect_pc", redirect_pc, 32'h0000_3024);
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b1, 32'h3020, 32'd0, 32'd0, 32'h3010, 1'b0, 32'd0, 1'b0);
        idleCycle();
        @(negedge clk);
        checkOutput("loop_ctr2_pred_f", {31'b0, pred_f}, 32'd1);
`endif

        idleCycle();
        idleCycle();
        @(negedge clk);
        checkEn = 1'b0;
        printSummary();
        $finish;
    end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter BTB_DEPTH, default 16, BTB entry count; power of 2, minimum 2.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  freezes PC register and BTB updates when high.
REQ-006 valid_d  in  1  decode-stage instruction is valid.
REQ-007 instr_d  in  32  decode-stage instruction word.
REQ-008 pc_d  in  32  PC of decode-stage instruction.
REQ-009 rs_val, rt_val  in  32 each  forwarded register operands for the decode-stage instruction.
REQ-010 br_type  in  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez; 7 treated as none.
REQ-011 jump  in  1  j/jal in decode; jr  in  1  jr/jalr in decode (jr wins over jump).
REQ-012 pred_d, pred_tgt_d  in  1/32  prediction travelling with the decode instruction.
REQ-013 pc_f, pc_plus4_f  out  32 each  fetch PC register and its +4.
REQ-014 pred_f, pred_tgt_f  out  1/32  fetch-stage prediction, forwarded to decode by the pipeline.
REQ-015 redirect, redirect_pc  out  1/32  mispredict correction; flush_f  out  1  equals redirect.

Function
REQ-016 Branch target SHALL be pc_d+4 + {sext(instr_d[15:0]),2'b00}, modulo 2^32; jump target {pc_d+4[31:28],instr_d[25:0],2'b00}; jr target rs_val.
REQ-017 Branch conditions: beq rs==rt; bne rs!=rt; blez/bgtz/bltz/bgez on signed rs_val versus 0.
REQ-018 actual_taken = jr | jump | condition true; actual_next = actual_taken ? target : pc_d+4.
REQ-019 mispredict = (pred_d != actual_taken) | (pred_d & actual_taken & pred_tgt_d != target).
REQ-020 redirect SHALL be combinational: valid_d & !stall & mispredict; redirect_pc = actual_next.
REQ-021 pc_f update priority per edge: reset -> RESET_PC; stall -> hold; redirect -> redirect_pc; else pred_f ? pred_tgt_f : pc_f+4.
REQ-022 Redirect latency: corrected address SHALL appear on pc_f exactly one cycle after redirect is high.
REQ-023 A redirect raised while stall is high SHALL be suppressed; it is re-evaluated when stall drops.
REQ-024 pc_plus4_f SHALL always equal pc_f+4 with 32-bit wrap (32'hFFFF_FFFC -> 0).

Reset
REQ-025 During reset: pc_f=RESET_PC, pc_plus4_f=RESET_PC+4, redirect=0, flush_f=0, pred_f=0, pred_tgt_f=RESET_PC+4.
REQ-026 Reset SHALL clear all BTB valid bits and override stall and redirect in the same cycle.

Configuration
REQ-027 Macro NPC_BTB_EN compiles the BTB in. Defined: prediction per REQ-028..031. Undefined: pred_f=0, pred_tgt_f=pc_plus4_f, no BTB storage; all taken control flow redirects.
REQ-028 BTB direct-mapped: index pc[log2(BTB_DEPTH)+1:2], tag remaining upper bits, entry = valid, tag, 32-bit target, 2-bit saturating counter.
REQ-029 Lookup combinational on pc_f: pred_f = hit & counter>=2; pred_tgt_f = pred_f ? entry target : pc_plus4_f.
REQ-030 Update at edge when valid_d & !stall & (br_type!=0 | jump), never for jr.
  - hit: counter +1 if taken, -1 if not, saturating at 0/3; target rewritten.
  - miss & taken: allocate, counter=2.
  - miss & not taken: no change.
REQ-031 Lookup and update of the same index in one cycle: lookup SHALL return pre-update contents.

Structure
REQ-032 Shared package npc_pkg SHALL hold br_type encodings and the RESET_PC default constant.
REQ-033 BTB SHALL be a sub-module npc_btb (lookup port, update port, clk/reset); it is instantiated only under NPC_BTB_EN.

Verification
REQ-034 reset held 2 cycles, release -> pc_f 32'h3000, 32'h3004, 32'h3008 on following edges.
REQ-035 beq at pc_d=32'h3010, imm 16'hFFFC, rs=rt=5, pred_d=0 -> redirect=1, redirect_pc=32'h3004, pc_f=32'h3004 next cycle.
REQ-036 Same beq with stall=1 for 3 cycles -> redirect=0 and pc_f held; redirect asserts in the cycle stall drops.
REQ-037 jr with rs_val=32'h0000_4000, pred_d=1, pred_tgt_d=32'h4000 -> redirect=0; with pred_tgt_d=32'h4004 -> redirect_pc=32'h4000.
REQ-038 NPC_BTB_EN: loop branch at 32'h3020 to 32'h3000 taken twice -> third fetch of 32'h3020 gives pred_f=1, pred_tgt_f=32'h3000, no redirect; then one not-taken -> redirect_pc=32'h3024, counter 2.
REQ-039 pc_f=32'hFFFF_FFFC, no prediction -> pc_plus4_f=0 and pc_f=0 next cycle.
